// File: rtl/fibo_stream.sv
// fibo_stream: Fibonacci-style sequence source on a valid/ready stream.
// Element a is presented on out_data. Each accepted element advances the
// pair (a, b) to (b, a+b). The mode chosen at start decides what happens
// when the W-bit sum carries out: wrap, saturate, or finish the stream.
module fibo_stream #(
  parameter int unsigned W     = 8,
  parameter int unsigned IDX_W = 16,
  parameter logic [W-1:0] SEED0 = '0,
  parameter logic [W-1:0] SEED1 = {{(W-1){1'b0}}, 1'b1}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [W-1:0]     load_a,
  input  logic [W-1:0]     load_b,
  input  logic             start,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic             ovf
);

  // FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_LAST = 2'd2;
  localparam logic [1:0] ST_HALT = 2'd3;

  // Overflow handling modes; the reserved code 3 falls through to wrap
  localparam logic [1:0] MODE_WRAP = 2'd0;
  localparam logic [1:0] MODE_SAT  = 2'd1;
  localparam logic [1:0] MODE_STOP = 2'd2;

  logic [1:0]       state_p0;
  logic [1:0]       mode_p0;
  logic [W-1:0]     a_p0;
  logic [W-1:0]     b_p0;
  logic [IDX_W-1:0] idx_p0;
  logic             ovf_p0;

  logic [W:0]       sum;
  logic             carry;
  logic             xfer;
  logic [W-1:0]     b_next;
  logic [IDX_W-1:0] idx_inc;

  // Wrapped W-bit result of the widened sum.
  function automatic logic [W-1:0] wrap_f(input logic [W:0] s);
    return s[W-1:0];
  endfunction

  // Saturated W-bit result: all-ones whenever the sum carried out.
  function automatic logic [W-1:0] sat_f(input logic [W:0] s);
    return s[W] ? {W{1'b1}} : s[W-1:0];
  endfunction

  // Successor of b for the active overflow mode. In stop mode b is frozen
  // so the final element presented from LAST is the last valid term.
  function automatic logic [W-1:0] next_b_f(input logic [W:0]   s,
                                            input logic [W-1:0] b_cur,
                                            input logic [1:0]   m);
    logic [W-1:0] r;
    r = wrap_f(s);
    if (s[W]) begin
      case (m)
        MODE_SAT:  r = sat_f(s);
        MODE_STOP: r = b_cur;
        default:   r = wrap_f(s);
      endcase
    end
    return r;
  endfunction

  // Next-term arithmetic and handshake decode
  always_comb begin
    sum     = {1'b0, a_p0} + {1'b0, b_p0};
    carry   = sum[W];
    xfer    = out_valid && out_ready;
    b_next  = next_b_f(sum, b_p0, mode_p0);
    idx_inc = idx_p0 + {{(IDX_W-1){1'b0}}, 1'b1};
  end

  // Sequence state, index, overflow flag and FSM; rst > load > start/transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0 <= ST_IDLE;
      mode_p0  <= MODE_WRAP;
      a_p0     <= SEED0;
      b_p0     <= SEED1;
      idx_p0   <= '0;
      ovf_p0   <= 1'b0;
    end else if (load) begin
      a_p0   <= load_a;
      b_p0   <= load_b;
      idx_p0 <= '0;
      ovf_p0 <= 1'b0;
      if (start) begin
        state_p0 <= ST_RUN;
        mode_p0  <= mode;
      end else begin
        state_p0 <= ST_IDLE;
      end
    end else begin
      case (state_p0)
        ST_IDLE: begin
          if (start) begin
            state_p0 <= ST_RUN;
            mode_p0  <= mode;
          end
        end
        ST_RUN: begin
          if (xfer) begin
            a_p0   <= b_p0;
            b_p0   <= b_next;
            idx_p0 <= idx_inc;
            if (carry) begin
              ovf_p0 <= 1'b1;
              if (mode_p0 == MODE_STOP) begin
                state_p0 <= ST_LAST;
              end
            end
          end
        end
        ST_LAST: begin
          if (xfer) begin
            a_p0     <= b_p0;
            idx_p0   <= idx_inc;
            state_p0 <= ST_HALT;
          end
        end
        default: begin
          // HALT: everything holds until load or rst
          state_p0 <= ST_HALT;
        end
      endcase
    end
  end

  // Outputs come straight from registers; no input reaches them combinationally
  always_comb begin
    out_valid = (state_p0 == ST_RUN) || (state_p0 == ST_LAST);
    out_data  = a_p0;
    out_idx   = idx_p0;
    ovf       = ovf_p0;
  end

endmodule
